// File: rtl/abc_input_debounce_if.sv
// Raw switch inputs and conditioned A/B/C levels with change strobe/mask.
// The master drives the raw inputs; the slave (debouncer) drives the clean levels.
interface abc_input_debounce_if;
  logic       a_raw;
  logic       b_raw;
  logic       c_raw;
  logic       A;
  logic       B;
  logic       C;
  logic       change_pulse;
  logic [2:0] changed_mask;

  modport master (
    output a_raw, b_raw, c_raw,
    input  A, B, C, change_pulse, changed_mask
  );

  modport slave (
    input  a_raw, b_raw, c_raw,
    output A, B, C, change_pulse, changed_mask
  );
endinterface

// File: rtl/abc_input_debounce.sv
// Three-channel switch conditioner: synchronizer plus counter debounce per channel,
// with registered clean levels and a one-cycle change strobe and mask.
//
// state | meaning
// IDLE  | synced input matches stable output, counter held at 0
// COUNT | synced input differs, counting consecutive differing samples
module abc_input_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  abc_input_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("abc_input_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("abc_input_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic {IDLE, COUNT} state_t;

  // Bit 2 = channel A, bit 1 = B, bit 0 = C, matching the {A,B,C} mask order.
  logic [2:0]             raw;
  logic [2:0]             synced;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             stable_q, stable_d;
  logic [2:0]             flip;
  state_t                 state_q [3];
  state_t                 state_d [3];
  logic [CNT_W-1:0]       cnt_q [3];
  logic [CNT_W-1:0]       cnt_d [3];
  logic                   change_pulse_q;
  logic [2:0]             changed_mask_q;

  assign raw = {bus.a_raw, bus.b_raw, bus.c_raw};

  always_comb begin
    for (int i = 0; i < 3; i++) synced[i] = sync_q[i][SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      stable_q       <= '0;
      change_pulse_q <= 1'b0;
      changed_mask_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      stable_q       <= stable_d;
      change_pulse_q <= |flip;
      changed_mask_q <= flip;
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (synced[i] != stable_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              stable_d[i] = synced[i];
            end else begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = COUNT;
            end
          end
        end
        COUNT: begin
          if (synced[i] == stable_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = synced[i];
            cnt_d[i]    = '0;
            state_d[i]  = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  assign flip = stable_d ^ stable_q;

  assign bus.A            = stable_q[2];
  assign bus.B            = stable_q[1];
  assign bus.C            = stable_q[0];
  assign bus.change_pulse = change_pulse_q;
  assign bus.changed_mask = changed_mask_q;

endmodule

// File: tb/tb_abc_input_debounce.sv
// Directed bench for abc_input_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Observed word is {A,B,C,change_pulse,changed_mask}; expectations are hand-derived.
module tb_abc_input_debounce;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  abc_input_debounce_if bus ();

  abc_input_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {bus.A, bus.B, bus.C, bus.change_pulse, bus.changed_mask};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    observed = obs();
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    bus.c_raw = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("reset_idle_low", 7'b000_0_000);
  endtask

  initial begin
    int cseq [6] = '{1, 0, 1, 1, 0, 1};

    // reset with all raws high, then simultaneous acceptance on all channels
    rst       = 1'b1;
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    bus.c_raw = 1'b1;
    tick();
    chk("reset_hold_1", 7'b000_0_000);
    tick();
    chk("reset_hold_2", 7'b000_0_000);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("reset_release_wait", 7'b000_0_000);
    end
    tick();
    chk("reset_release_rise", 7'b111_1_111);
    tick();
    chk("reset_release_after", 7'b111_0_000);

    // clean rising edge on A
    do_reset();
    bus.a_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("clean_wait", 7'b000_0_000);
    end
    tick();
    chk("clean_rise", 7'b100_1_100);
    tick();
    chk("clean_after", 7'b100_0_000);

    // B glitch of 3 cycles is rejected
    bus.b_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("glitch_b", 7'b100_0_000);
      if (e == 3) bus.b_raw = 1'b0;
    end

    // C bounces, then rises 6 edges after the final 0->1
    bus.c_raw = 1'(cseq[0]);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("bounce_wait", 7'b100_0_000);
      bus.c_raw = (e < 6) ? 1'(cseq[e]) : 1'b1;
    end
    tick();
    chk("bounce_rise", 7'b101_1_001);
    tick();
    chk("bounce_after", 7'b101_0_000);

    // staggered A then B: back-to-back strobes
    do_reset();
    bus.a_raw = 1'b1;
    tick();
    chk("stagger_wait", 7'b000_0_000);
    bus.b_raw = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      tick();
      chk("stagger_wait", 7'b000_0_000);
    end
    tick();
    chk("stagger_a", 7'b100_1_100);
    tick();
    chk("stagger_b", 7'b110_1_010);
    tick();
    chk("stagger_after", 7'b110_0_000);

    // reset mid-count abandons the pending change
    do_reset();
    bus.a_raw = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("midrst_count", 7'b000_0_000);
    end
    rst = 1'b1;
    tick();
    chk("midrst_in_reset", 7'b000_0_000);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("midrst_restart", 7'b000_0_000);
    end
    tick();
    chk("midrst_rise", 7'b100_1_100);
    tick();
    chk("midrst_after", 7'b100_0_000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
